addsub_nibble_seq: RTL and testbench
====================================

Name: addsub_nibble_seq

Overview:
- Nibble-serial add/subtract sequencer for wide operands.
- Shares one 4-bit carry-lookahead slice (one full_adder_4bit instance) across all nibbles of a 4*NIBBLES-bit operation, processing LSB nibble first.
- Carry is held in a register between nibbles.
- Sits between a requester issuing start/operands and a consumer taking the result over a valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start_valid  input  1  requester presents an operation
- start_ready  output  1  block can accept an operation
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled only on start handshake
- a  input  W  operand A; sampled only on start handshake
- b  input  W  operand B; sampled only on start handshake
- res_valid  output  1  result fields valid
- res_ready  input  1  consumer takes result
- result  output  W  sum or difference, modulo 2^W
- cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned), 0 = borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  result == 0
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready, capture a into A_reg, capture (op ? ~b : b) into B_reg, set carry_reg=op, set idx=0, go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle, feed nibble idx of A_reg/B_reg and carry_reg to the slice.
  - Write the slice sum into result nibble idx; carry_reg <= slice cout; idx++.
  - On the cycle idx==NIBBLES-1, also latch cout=slice cout and compute ovf=(A_reg[W-1]==B_reg[W-1]) && (sum[3]!=A_reg[W-1]).
  - Compute zero from the complete result, then go to DONE.
- DONE:
  - res_valid=1; result, cout, ovf and zero are held stable.
  - On res_ready, go to IDLE.
  - start_ready=0, so start_valid is ignored.
- Latency: handshake in cycle T; RUN spans cycles T+1..T+NIBBLES; res_valid is first high at T+NIBBLES+1. Minimum initiation interval is NIBBLES+2 cycles with res_ready held high.
- No back-to-back overlap: a new start is accepted only in IDLE, including the cycle right after the res_ready handshake.
- Operands and op changing after the handshake have no effect.
- idx width is clog2(NIBBLES); idx resets to 0 on each accept and never wraps in RUN.
- Outputs result/cout/ovf/zero are registered. They keep their last values in IDLE and are overwritten only during the next RUN. They are meaningful only while res_valid=1.
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, result=0, cout=0, ovf=0, zero=0, carry_reg=0, idx=0.
- rst has priority over every other event, including mid-RUN or mid-DONE. The operation in flight is discarded with no res_valid pulse, and outputs take reset values on the next edge.
- rst and start_valid asserted together: reset wins and the operation is not accepted.
- res_ready asserted outside DONE: ignored.

Test Plan:
- NIBBLES=4, add a=0x1234, b=0x0FCD -> res_valid at T+5, result=0x2201, cout=0, ovf=0, zero=0.
- Sub a=0x0005, b=0x0007 -> result=0xFFFE, cout=0 (borrow), ovf=0. Sub a=0x8000, b=0x0001 -> result=0x7FFF, cout=1, ovf=1.
- Add a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, zero=1, ovf=0. Add a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, ovf=1.
- Backpressure: res_ready low for 3 cycles in DONE -> res_valid stays 1, outputs stable, start_ready=0, start_valid ignored. Then res_ready=1 -> IDLE next cycle, start_ready=1.
- Operand change after handshake (a/b/op toggled every cycle in RUN) -> result equals the captured operation.
- Back-to-back starts with res_ready tied high -> accepts spaced NIBBLES+2 cycles.
- rst pulsed in second RUN cycle -> next cycle: IDLE, res_valid=0, result=0, cout=0, ovf=0, zero=0, start_ready=1. A subsequent sub a=0x0010, b=0x0010 -> result=0x0000, cout=1, zero=1.
- rst asserted with start_valid in the same cycle -> no accept, busy stays 0.

Source files
------------

// File: rtl/addsub_nibble_seq.sv
// Nibble-serial add/subtract sequencer sharing one 4-bit carry-lookahead slice.
// LSB nibble first; carry is held in a register between nibbles.

module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c;
endmodule

module addsub_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic                   zero,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_q;
    logic [IW-1:0] idx;

    logic          accept;
    logic          step;
    logic          last;
    logic [3:0]    s_a;
    logic [3:0]    s_b;
    logic [3:0]    s_sum;
    logic          s_cout;
    logic [W-1:0]  next_res;

    assign s_a = a_reg[{idx, 2'b00} +: 4];
    assign s_b = b_reg[{idx, 2'b00} +: 4];

    full_adder_4bit u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Result with the current nibble merged in, so zero sees the full word.
    always_comb begin
        next_res = result;
        next_res[{idx, 2'b00} +: 4] = s_sum;
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        last        = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= op ? ~b : b;
                carry_q <= op;
                idx     <= '0;
            end
            if (step) begin
                result  <= next_res;
                carry_q <= s_cout;
                if (last) begin
                    cout <= s_cout;
                    ovf  <= (a_reg[W-1] == b_reg[W-1])
                          && (s_sum[3] != a_reg[W-1]);
                    zero <= (next_res == '0);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Self-checking bench for addsub_nibble_seq (NIBBLES=4, W=16).
// Reference model uses plain integer arithmetic on whole operands.

module tb_addsub_nibble_seq;
    localparam int NIBBLES = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf),
        .zero        (zero),
        .busy        (busy)
    );

    function automatic logic [18:0] model(input logic o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        int ua = int'(x);
        int ub = int'(y);
        int sa = int'($signed(x));
        int sb = int'($signed(y));
        int u;
        int s;
        logic [15:0] r;
        logic c;
        logic v;
        if (o) begin
            u = ua - ub;
            s = sa - sb;
            c = (ua >= ub);
        end else begin
            u = ua + ub;
            s = sa + sb;
            c = (u > 65535);
        end
        r = u[15:0];
        v = (s > 32767) || (s < -32768);
        return {r, c, v, (r == 16'h0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic o, input logic [15:0] x,
                          input logic [15:0] y, input bit scramble,
                          input string name);
        logic [18:0] exp;
        int n;
        exp = model(o, x, y);
        start_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ready: got %b want 1", name, start_ready);
        end
        step();
        start_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
                op = ~op;
            end
            step();
            n++;
        end
        checks++;
        if (n != NIBBLES) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, NIBBLES);
        end
        checks++;
        if ({result, cout, ovf, zero} !== exp) begin
            errors++;
            $display("FAIL %s outputs: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     name, result, cout, ovf, zero,
                     exp[18:3], exp[2], exp[1], exp[0]);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got rv=%b sr=%b busy=%b want 0 1 0",
                     name, res_valid, start_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({start_ready, res_valid, busy, result, cout, ovf, zero} !==
            {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got sr=%b rv=%b busy=%b r=%h c=%b v=%b z=%b want 1 0 0 0000 0 0 0",
                     start_ready, res_valid, busy, result, cout, ovf, zero);
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 16'h1234, 16'h0FCD, 1'b0, "add_basic");
        run_op(1'b1, 16'h0005, 16'h0007, 1'b0, "sub_borrow");
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, "add_wrap_zero");
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    endtask

    task automatic test_backpressure();
        logic [18:0] exp;
        int n;
        exp = model(1'b0, 16'h1111, 16'h2222);
        start_valid = 1'b1;
        op = 1'b0;
        a = 16'h1111;
        b = 16'h2222;
        step();
        start_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        start_valid = 1'b1;
        op = 1'b1;
        a = 16'hABCD;
        b = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || start_ready !== 1'b0 ||
                {result, cout, ovf, zero} !== exp) begin
                errors++;
                $display("FAIL backpressure[%0d]: got rv=%b sr=%b r=%h want rv=1 sr=0 r=%h",
                         i, res_valid, start_ready, result, exp[18:3]);
            end
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got sr=%b rv=%b busy=%b want 1 0 0",
                     start_ready, res_valid, busy);
        end
    endtask

    task automatic test_operand_change();
        run_op(1'b0, 16'h4321, 16'h1357, 1'b1, "scramble_add");
        run_op(1'b1, 16'h0100, 16'h0EEF, 1'b1, "scramble_sub");
    endtask

    task automatic test_back_to_back();
        logic [18:0] q[$];
        logic [18:0] got;
        logic [18:0] exp;
        int last_acc = -1;
        int nacc = 0;
        bit pending = 1'b0;
        res_ready = 1'b1;
        start_valid = 1'b1;
        op = 1'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 45) start_valid = 1'b0;
            if (res_valid === 1'b1) begin
                got = {result, cout, ovf, zero};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got r=%h want no result", result);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL b2b_result: got %h want %h", got, exp);
                    end
                end
            end
            if (start_valid && start_ready === 1'b1) begin
                q.push_back(model(op, a, b));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != NIBBLES + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d want %0d",
                                 cyc - last_acc, NIBBLES + 2);
                    end
                end
                last_acc = cyc;
                nacc++;
                pending = 1'b1;
            end
            step();
            if (pending) begin
                op = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                pending = 1'b0;
            end
        end
        res_ready = 1'b0;
        checks++;
        if (q.size() != 0 || nacc < 5) begin
            errors++;
            $display("FAIL b2b_drain: got left=%0d accepts=%0d want 0 and >=5",
                     q.size(), nacc);
        end
    endtask

    task automatic test_reset_mid_run();
        start_valid = 1'b1;
        op = 1'b0;
        a = 16'h1234;
        b = 16'h0FCD;
        step();
        start_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({start_ready, res_valid, busy, result, cout, ovf, zero} !==
            {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_run: got sr=%b rv=%b busy=%b r=%h c=%b v=%b z=%b want 1 0 0 0000 0 0 0",
                     start_ready, res_valid, busy, result, cout, ovf, zero);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_pulse[%0d]: got rv=%b busy=%b want 0 0",
                         i, res_valid, busy);
            end
        end
        run_op(1'b1, 16'h0010, 16'h0010, 1'b0, "sub_after_reset");
    endtask

    task automatic test_reset_with_start();
        rst = 1'b1;
        start_valid = 1'b1;
        op = 1'b0;
        a = 16'h0F00;
        b = 16'h00F0;
        step();
        rst = 1'b0;
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_with_start: got busy=%b sr=%b want 0 1",
                     busy, start_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_start_next: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_operand_change();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_with_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
